// File: rtl/prefetch_fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its requester, the prefetch FIFO read port and the downstream stream.
// The slave modport is the reader's view; master is the surrounding environment.
interface prefetch_fifo_burst_reader_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_vld;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              busy;
    logic [LEN_W-1:0]  rem_cnt;

    modport slave (
        input  req_valid, req_len, fifo_rd_data, fifo_rd_vld, out_ready,
        output req_ready, fifo_rd_en, out_data, out_valid, out_last, done, busy, rem_cnt
    );

    modport master (
        output req_valid, req_len, fifo_rd_data, fifo_rd_vld, out_ready,
        input  req_ready, fifo_rd_en, out_data, out_valid, out_last, done, busy, rem_cnt
    );
endinterface

// File: rtl/prefetch_fifo_burst_reader.sv
// Pops a requested number of words from the prefetch FIFO and forwards them through a
// 2-entry output buffer, tagging the final word and pulsing done once it is accepted.
module prefetch_fifo_burst_reader #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    prefetch_fifo_burst_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  rem_q;
    logic              done_q;

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [1:0]        last_q;
    logic [1:0]        last_d;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;

    logic accept;
    logic buf_full;
    logic rd_en;
    logic pop;
    logic pop_last;
    logic req_fire;

    // A full buffer may still take a word when its head leaves in the same cycle.
    assign accept   = (cnt_q != 2'd0) & bus.out_ready;
    assign buf_full = (cnt_q == 2'd2) & ~bus.out_ready;
    assign rd_en    = (state_q == FETCH) & (rem_q != '0) & ~buf_full;
    assign pop      = rd_en & bus.fifo_rd_vld;
    assign pop_last = (rem_q == LEN_W'(1));
    assign req_fire = (state_q == IDLE) & bus.req_valid;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_rd_en = rd_en;
    assign bus.rem_cnt    = rem_q;
    assign bus.done       = done_q;
    assign bus.out_valid  = (cnt_q != 2'd0);
    assign bus.out_data   = data_q[0];
    assign bus.out_last   = last_q[0];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        if (bus.req_len != '0) begin
                            rem_q   <= bus.req_len;
                            state_q <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (pop) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (pop_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && last_q[0]) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry 0 is always the head; a departing head shifts entry 1 forward.
    always_comb begin
        data_d = data_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        case ({pop, accept})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data_d[0] = bus.fifo_rd_data;
                    last_d[0] = pop_last;
                end else begin
                    data_d[1] = bus.fifo_rd_data;
                    last_d[1] = pop_last;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                data_d[0] = data_q[1];
                last_d[0] = last_q[1];
                cnt_d     = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data_d[0] = bus.fifo_rd_data;
                    last_d[0] = pop_last;
                end else begin
                    data_d[0] = data_q[1];
                    last_d[0] = last_q[1];
                    data_d[1] = bus.fifo_rd_data;
                    last_d[1] = pop_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
        end else begin
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prefetch_fifo_burst_reader.sv
// Bench for the burst reader: a queue-based FIFO source and word-count model predict pops,
// buffer occupancy, data order, last tagging and done timing for each burst.
module tb_prefetch_fifo_burst_reader;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 12;

    logic rd_clk = 1'b0;
    logic rd_rst;

    always #5 rd_clk = ~rd_clk;

    prefetch_fifo_burst_reader_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    prefetch_fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DATA_W-1:0] src [$];
    int   popCnt, accCnt, doneCnt, doneWrong, lastCnt, lastErr, dataErr;
    int   enErr, validErr, remErr, stableErr, popsAt9, enAt9;
    logic [DATA_W-1:0] dataAt9;
    bit   timedOut, reqReadyObs, busyReadyObs;
    logic rstValid, rstLast, rstDone, rstEn, rstBusy, rstReady;
    logic [DATA_W-1:0] rstData;
    logic [LEN_W-1:0]  rstRem;

    // Runs one burst: the FIFO head is always the next unpopped source word, and every cycle
    // the observed handshake is compared to what the word counts say must happen.
    task automatic applyStimulus(input int len, input int vldMode, input int rdyMode,
                                 input int abortPops, input int busyReqAt, input bit seqData,
                                 input int budget);
        int cyc, tail, lastAccCycle, occ;
        bit finished, prevStall, expEn, acc;
        logic [DATA_W-1:0] prevData;
        logic prevLast;
        popCnt = 0; accCnt = 0; doneCnt = 0; doneWrong = 0; lastCnt = 0; lastErr = 0;
        dataErr = 0; enErr = 0; validErr = 0; remErr = 0; stableErr = 0;
        popsAt9 = -1; enAt9 = -1; dataAt9 = '0; busyReadyObs = 1'b1;
        src.delete();
        for (int i = 0; i < len + 4; i++)
            src.push_back(seqData ? DATA_W'(i + 1) : DATA_W'($urandom));
        @(negedge rd_clk);
        bus.req_valid = 1'b1; bus.req_len = LEN_W'(len);
        bus.fifo_rd_vld = 1'b0; bus.out_ready = 1'b1;
        #1 reqReadyObs = bus.req_ready;
        @(posedge rd_clk);
        cyc = 0; tail = -1; lastAccCycle = (len == 0) ? -1 : -10;
        finished = 0; prevStall = 0; prevData = '0; prevLast = 1'b0;
        while (!finished && cyc < budget) begin
            if (abortPops >= 0 && popCnt == abortPops) begin
                #3 rd_rst = 1'b1;
                #1;
                rstValid = bus.out_valid; rstLast = bus.out_last; rstDone = bus.done;
                rstEn = bus.fifo_rd_en; rstBusy = bus.busy; rstReady = bus.req_ready;
                rstData = bus.out_data; rstRem = bus.rem_cnt;
                repeat (2) begin @(posedge rd_clk); #1 if (bus.done === 1'b1) doneCnt++; end
                @(negedge rd_clk) rd_rst = 1'b0;
                repeat (3) begin @(posedge rd_clk); #1 if (bus.done === 1'b1) doneCnt++; end
                finished = 1;
            end else begin
                @(negedge rd_clk);
                bus.req_valid   = (cyc == busyReqAt);
                bus.req_len     = LEN_W'(7);
                bus.fifo_rd_vld = (vldMode == 0) ? 1'b1 : (vldMode == 1) ? (cyc % 3 == 0) : 1'($urandom);
                bus.out_ready   = (rdyMode == 0) ? 1'b1 : (rdyMode == 1) ? (cyc >= 10) : 1'($urandom);
                bus.fifo_rd_data = src[popCnt];
                #1;
                occ   = popCnt - accCnt;
                expEn = (popCnt < len) && !(occ == 2 && !bus.out_ready);
                if (bus.fifo_rd_en !== expEn) enErr++;
                if (bus.out_valid !== (occ > 0)) validErr++;
                if (bus.rem_cnt !== LEN_W'(len - popCnt)) remErr++;
                if (prevStall && (bus.out_data !== prevData || bus.out_last !== prevLast
                                  || bus.out_valid !== 1'b1)) stableErr++;
                if (cyc == busyReqAt) busyReadyObs = bus.req_ready;
                if (bus.done === 1'b1) begin
                    doneCnt++;
                    if (cyc != lastAccCycle + 1) doneWrong++;
                    if (tail < 0) tail = 3;
                end else if (cyc == lastAccCycle + 1) begin
                    doneWrong++;
                end
                acc = (bus.out_valid === 1'b1) && bus.out_ready;
                if (acc) begin
                    if (accCnt >= len || bus.out_data !== src[accCnt]) dataErr++;
                    if (bus.out_last === 1'b1) lastCnt++;
                    if (bus.out_last !== (accCnt == len - 1)) lastErr++;
                    if (accCnt == len - 1) lastAccCycle = cyc;
                    accCnt++;
                end
                if (bus.fifo_rd_vld && bus.fifo_rd_en === 1'b1) popCnt++;
                prevStall = (bus.out_valid === 1'b1) && !bus.out_ready;
                prevData  = bus.out_data;
                prevLast  = bus.out_last;
                if (cyc == 9) begin popsAt9 = popCnt; enAt9 = int'(bus.fifo_rd_en); dataAt9 = bus.out_data; end
                @(posedge rd_clk);
                cyc++;
                if (tail > 0) tail--;
                if (tail == 0) finished = 1;
            end
        end
        timedOut = !finished;
        bus.req_valid = 1'b0; bus.fifo_rd_vld = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_len = '0; bus.fifo_rd_data = '0;
        bus.fifo_rd_vld = 1'b0; bus.out_ready = 1'b0;
        rd_rst = 1'b1;
        #12;
        testsRun++; if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); end
        testsRun++; if (bus.out_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset out_last: got %b want 0", bus.out_last); end
        testsRun++; if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset done: got %b want 0", bus.done); end
        testsRun++; if (bus.fifo_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset fifo_rd_en: got %b want 0", bus.fifo_rd_en); end
        testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset busy: got %b want 0", bus.busy); end
        testsRun++; if (bus.req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset req_ready: got %b want 1", bus.req_ready); end
        testsRun++; if (bus.out_data !== '0) begin testsFailed++; $display("[TB] FAIL reset out_data: got %h want 0", bus.out_data); end
        testsRun++; if (bus.rem_cnt !== '0) begin testsFailed++; $display("[TB] FAIL reset rem_cnt: got %0d want 0", bus.rem_cnt); end
        @(negedge rd_clk) rd_rst = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_basic_burst();
        applyStimulus(4, 0, 0, -1, -1, 1'b1, 40);
        testsRun++; if (timedOut || !reqReadyObs) begin testsFailed++; $display("[TB] FAIL basic completion: timeout %b req_ready %b want 0/1", timedOut, reqReadyObs); end
        testsRun++; if (popCnt !== 4 || accCnt !== 4) begin testsFailed++; $display("[TB] FAIL basic counts: pops %0d accepts %0d want 4/4", popCnt, accCnt); end
        testsRun++; if (dataErr !== 0 || lastErr !== 0 || lastCnt !== 1) begin testsFailed++; $display("[TB] FAIL basic data/last: dataErr %0d lastErr %0d lasts %0d want 0/0/1", dataErr, lastErr, lastCnt); end
        testsRun++; if (doneCnt !== 1 || doneWrong !== 0) begin testsFailed++; $display("[TB] FAIL basic done: count %0d wrong %0d want 1/0", doneCnt, doneWrong); end
        testsRun++; if (enErr + validErr + remErr !== 0) begin testsFailed++; $display("[TB] FAIL basic timing: en %0d valid %0d rem %0d want 0", enErr, validErr, remErr); end
    endtask

    task automatic test_backpressure();
        applyStimulus(6, 0, 1, -1, -1, 1'b0, 80);
        testsRun++; if (popsAt9 !== 2 || enAt9 !== 0) begin testsFailed++; $display("[TB] FAIL backpressure stall: pops %0d en %0d want 2/0", popsAt9, enAt9); end
        testsRun++; if (dataAt9 !== src[0]) begin testsFailed++; $display("[TB] FAIL backpressure head: got %h want %h", dataAt9, src[0]); end
        testsRun++; if (stableErr !== 0) begin testsFailed++; $display("[TB] FAIL backpressure stability: got %0d want 0", stableErr); end
        testsRun++; if (timedOut || accCnt !== 6 || dataErr !== 0) begin testsFailed++; $display("[TB] FAIL backpressure delivery: accepts %0d dataErr %0d timeout %b want 6/0/0", accCnt, dataErr, timedOut); end
        testsRun++; if (enErr + validErr + remErr !== 0) begin testsFailed++; $display("[TB] FAIL backpressure timing: en %0d valid %0d rem %0d want 0", enErr, validErr, remErr); end
    endtask

    task automatic test_underflow();
        applyStimulus(5, 1, 0, -1, -1, 1'b0, 80);
        testsRun++; if (popCnt !== 5 || accCnt !== 5) begin testsFailed++; $display("[TB] FAIL underflow counts: pops %0d accepts %0d want 5/5", popCnt, accCnt); end
        testsRun++; if (dataErr !== 0 || lastCnt !== 1 || doneCnt !== 1) begin testsFailed++; $display("[TB] FAIL underflow data: dataErr %0d lasts %0d dones %0d want 0/1/1", dataErr, lastCnt, doneCnt); end
        testsRun++; if (remErr + enErr !== 0 || timedOut) begin testsFailed++; $display("[TB] FAIL underflow rem/en: rem %0d en %0d timeout %b want 0/0/0", remErr, enErr, timedOut); end
    endtask

    task automatic test_zero_and_busy();
        applyStimulus(0, 0, 0, -1, -1, 1'b0, 20);
        testsRun++; if (doneCnt !== 1 || doneWrong !== 0) begin testsFailed++; $display("[TB] FAIL zero-length done: count %0d wrong %0d want 1/0", doneCnt, doneWrong); end
        testsRun++; if (validErr !== 0 || popCnt !== 0 || enErr !== 0) begin testsFailed++; $display("[TB] FAIL zero-length quiet: valid %0d pops %0d en %0d want 0", validErr, popCnt, enErr); end
        applyStimulus(5, 0, 2, -1, 2, 1'b0, 80);
        testsRun++; if (busyReadyObs !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy req_ready: got %b want 0", busyReadyObs); end
        testsRun++; if (popCnt !== 5 || remErr !== 0 || doneCnt !== 1 || dataErr !== 0) begin testsFailed++; $display("[TB] FAIL busy ignored: pops %0d rem %0d dones %0d data %0d want 5/0/1/0", popCnt, remErr, doneCnt, dataErr); end
    endtask

    task automatic test_reset_mid_burst();
        applyStimulus(8, 0, 0, 3, -1, 1'b0, 80);
        testsRun++; if (rstValid !== 1'b0 || rstLast !== 1'b0 || rstDone !== 1'b0 || rstEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset outputs: valid %b last %b done %b en %b want 0", rstValid, rstLast, rstDone, rstEn); end
        testsRun++; if (rstBusy !== 1'b0 || rstReady !== 1'b1 || rstData !== '0 || rstRem !== '0) begin testsFailed++; $display("[TB] FAIL midreset state: busy %b ready %b data %h rem %0d want 0/1/0/0", rstBusy, rstReady, rstData, rstRem); end
        testsRun++; if (doneCnt !== 0) begin testsFailed++; $display("[TB] FAIL midreset done: got %0d want 0", doneCnt); end
        applyStimulus(2, 0, 0, -1, -1, 1'b0, 40);
        testsRun++; if (timedOut || accCnt !== 2 || dataErr !== 0 || doneCnt !== 1 || doneWrong !== 0) begin testsFailed++; $display("[TB] FAIL post-reset burst: accepts %0d data %0d dones %0d wrong %0d want 2/0/1/0", accCnt, dataErr, doneCnt, doneWrong); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            applyStimulus($urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(0, 2), -1, -1, 1'b0, 600);
            testsRun++; if (timedOut || dataErr + lastErr + stableErr !== 0 || doneCnt !== 1 || doneWrong !== 0) begin testsFailed++; $display("[TB] FAIL random burst %0d: timeout %b data %0d last %0d stable %0d dones %0d wrong %0d want 0", k, timedOut, dataErr, lastErr, stableErr, doneCnt, doneWrong); end
            testsRun++; if (enErr + validErr + remErr !== 0) begin testsFailed++; $display("[TB] FAIL random timing %0d: en %0d valid %0d rem %0d want 0", k, enErr, validErr, remErr); end
        end
    endtask

    task automatic test_max_length();
        applyStimulus(4095, 0, 2, -1, -1, 1'b0, 30000);
        testsRun++; if (timedOut || popCnt !== 4095 || accCnt !== 4095) begin testsFailed++; $display("[TB] FAIL max counts: pops %0d accepts %0d timeout %b want 4095/4095/0", popCnt, accCnt, timedOut); end
        testsRun++; if (lastCnt !== 1 || lastErr !== 0 || doneCnt !== 1 || doneWrong !== 0) begin testsFailed++; $display("[TB] FAIL max last/done: lasts %0d lastErr %0d dones %0d wrong %0d want 1/0/1/0", lastCnt, lastErr, doneCnt, doneWrong); end
        testsRun++; if (remErr + enErr + dataErr + stableErr !== 0) begin testsFailed++; $display("[TB] FAIL max integrity: rem %0d en %0d data %0d stable %0d want 0", remErr, enErr, dataErr, stableErr); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_underflow();
        test_zero_and_busy();
        test_reset_mid_burst();
        test_back_to_back();
        test_max_length();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/prefetch_fifo_burst_reader.md
Name: prefetch_fifo_burst_reader

Overview:
- Consumer for the read port of the team's prefetch FIFO. Runs in the rd_clk domain.
- On a burst request of req_len words, pops exactly that many words using the FIFO's rd_vld/rd_en handshake.
- Forwards the words to a downstream valid/ready stream through a 2-entry output buffer, tags the final word with out_last, and pulses done.
- Used by video line fetch: one request per line.

Parameters:
- DATA_W, 16, width of FIFO read data and out_data.
- LEN_W, 12, width of req_len and the word counters. Max burst is 2^LEN_W-1.

Ports:
- rd_clk  in  1  read-side clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  burst request present.
- req_ready  out  1  block idle and able to accept a request.
- req_len  in  LEN_W  words in the burst; sampled when req_valid&req_ready.
- fifo_rd_data  in  DATA_W  FIFO head word; valid while fifo_rd_vld.
- fifo_rd_vld  in  1  FIFO head word valid.
- fifo_rd_en  out  1  pop request. A pop occurs when fifo_rd_vld&fifo_rd_en.
- out_data  out  DATA_W  downstream data.
- out_valid  out  1  downstream data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.
- done  out  1  one-cycle pulse when the burst is complete.
- busy  out  1  high in any state other than IDLE.
- rem_cnt  out  LEN_W  words not yet popped in the current burst.

Behaviour:
Reset (rd_rst high, async; released synchronously to rd_clk):
- state=IDLE, rem_cnt=0, buffer empty.
- out_valid=0, out_last=0, done=0, fifo_rd_en=0, busy=0, req_ready=1, out_data=0.
- A reset mid-burst discards buffered words and the remaining count. No done pulse is produced.

State machine IDLE -> FETCH -> DRAIN -> IDLE:
- IDLE:
  - req_ready=1.
  - On req_valid with req_len!=0: rem_cnt<=req_len, go to FETCH.
  - On req_valid with req_len==0: accept, done=1 the next cycle, stay in IDLE, no data moves.
- FETCH:
  - fifo_rd_en = (rem_cnt!=0) & ~buf_full, where buf_full means 2 entries are held and none leaves this cycle.
  - Each pop: rem_cnt decrements by 1; fifo_rd_data is written into the buffer tail with last = (rem_cnt==1).
  - When the final pop occurs (rem_cnt 1->0), go to DRAIN.
  - fifo_rd_vld low: no pop, no counter change. The block stalls indefinitely.
- DRAIN:
  - fifo_rd_en=0.
  - When the word tagged last is accepted (out_valid&out_ready&out_last): done=1 the next cycle, return to IDLE.
  - req_ready stays 0 until IDLE.

Output buffer (2 entries, registered):
- out_valid = buffer not empty. out_data/out_last = head entry.
- Latency: a word popped in cycle t appears on out_data in cycle t+1.
- A simultaneous pop and downstream accept in the same cycle is legal. Occupancy is unchanged and order is preserved.
- With out_ready held high and fifo_rd_vld held high, throughput is 1 word/cycle with no bubbles.
- out_data, out_valid and out_last must hold stable while out_valid&~out_ready.

Boundary conditions:
- Never pop more than req_len words: fifo_rd_en=0 whenever rem_cnt==0.
- Never drop a word: fifo_rd_en=0 when the buffer is full and out_ready=0.
- A req_len of 2^LEN_W-1 must count correctly with no wrap.
- req_valid while busy is ignored (req_ready=0); the request is not captured.
- fifo_rd_en may assert while fifo_rd_vld=0; this has no effect, matching the FIFO's pop rule.

Test Plan:
- Basic burst: reset; req_len=4, FIFO holds 0x0001..0x0004, out_ready=1 -> out_data 0x0001..0x0004 on 4 consecutive cycles starting 1 cycle after the first pop; out_last only on 0x0004; done 1 cycle after its accept; rem_cnt 4,3,2,1,0.
- Backpressure: req_len=6, out_ready=0 for 10 cycles then 1 -> exactly 2 pops, then fifo_rd_en=0 and out_data=first word held stable; after release all 6 words delivered in order with no loss or duplicates.
- FIFO underflow stall: fifo_rd_vld toggles 1,0,0,1,... during req_len=5 -> pops only on cycles with fifo_rd_vld=1; 5 words total; FIFO word 6 is never popped.
- Zero-length and busy requests: req_len=0 -> done pulse next cycle, out_valid stays 0; a second req_valid during a running burst -> req_ready=0, request ignored.
- Reset mid-burst: assert rd_rst after 3 of 8 words -> outputs return to reset values immediately (async), busy=0, req_ready=1, no done pulse; a following req_len=2 completes normally.
- Max length: req_len=4095 with random out_ready -> 4095 words, a single out_last, a single done, rem_cnt reaches 0 without wrap.
